// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption round sequencer.
//
// Accepts a 128-bit block on a valid/ready input and applies the initial
// AddRoundKey (in_block ^ round_key with dp_round = 0). It then steps the
// external combinational round datapath once per cycle for NR rounds. The
// result is held on a valid/ready output until downstream takes it.
//
// Handshake rule (both interfaces): a transfer happens on a rising clk edge
// where valid and ready are both 1. The controller raises ready only in IDLE.
// out_valid, once high, stays high with out_block stable until the transfer.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_block = plaintext
//   round_key             round key for dp_round, from the key schedule
//   dp_round/dp_state     round index and state driven into the datapath
//   dp_last               final round, the datapath bypasses MixColumns
//   dp_result             datapath output for dp_state/dp_round/round_key
//   out_valid/out_ready   output handshake, out_block = ciphertext
//   abort                 (AES_ROUND_CTRL_ABORT_EN only) synchronous flush
//   dbg_state             current FSM state, for observation only
//
// Build option: define AES_ROUND_CTRL_ABORT_EN to add the abort input.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] round_key,
  output logic [3:0]   dp_round,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic [1:0]   dbg_state
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic [127:0] state_reg_q, state_reg_d;
  logic         abort_w;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_cnt_q <= 4'd0;
      state_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      state_reg_q <= state_reg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    state_reg_d = state_reg_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    dp_last     = 1'b0;

    case (state_q)
      IDLE: begin
        // round_cnt is 0 here, so round_key is the initial whitening key.
        in_ready = ~abort_w;
        if (in_valid && !abort_w) begin
          state_reg_d = in_block ^ round_key;
          round_cnt_d = 4'd1;
          state_d     = ROUND;
        end
      end
      ROUND: begin
        dp_last     = (round_cnt_q == NR_L);
        state_reg_d = dp_result;
        if (round_cnt_q < NR_L) begin
          round_cnt_d = round_cnt_q + 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        // An abort in this cycle voids the output transfer.
        out_valid = ~abort_w;
        if (out_ready) begin
          state_d     = IDLE;
          round_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = IDLE;
        round_cnt_d = 4'd0;
      end
    endcase

    if (abort_w && state_q != IDLE) begin
      state_d     = IDLE;
      round_cnt_d = 4'd0;
      state_reg_d = '0;
    end
  end

  assign dp_round  = round_cnt_q;
  assign dp_state  = state_reg_q;
  assign out_block = state_reg_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl. It supplies an AES-128 round datapath and
// key schedule as plain functions. A monitor predicts every ciphertext with
// a whole-block AES reference and compares it at each output transfer.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_block = '0;
  logic         in_ready, dp_last, out_valid;
  logic [127:0] round_key, dp_state, dp_result, out_block;
  logic [3:0]   dp_round;
  logic [1:0]   dbg_state;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [127:0] exp_q[$];
  logic [127:0] cur_key = FIPS_KEY;
  logic [1407:0] cur_ks;
  bit b2b = 0;
  int last_acc = -1;
  int acc_edge = 0;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .round_key(round_key), .dp_round(dp_round), .dp_state(dp_state),
    .dp_last(dp_last), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (a^254), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic last);
    logic [7:0] a[16];
    logic [7:0] b[16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        b[rr+4*c] = sbox(a[rr + 4*((c + rr) % 4)]);
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a[4*c+0] = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
      for (int i = 0; i < 16; i++) b[i] = a[i];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      ks[1407-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [1407:0] ks;
    logic [127:0] s;
    ks = key_expand(key);
    s = pt ^ ks[1407 -: 128];
    for (int r = 1; r <= NR; r++) s = aes_round(s, ks[1407-128*r -: 128], r == NR);
    return s;
  endfunction

  // ---------------- environment: key schedule + round datapath ----------------
  assign cur_ks = key_expand(cur_key);

  always_comb begin
    round_key = '0;
    if (dp_round <= 4'd10) round_key = cur_ks[1407-128*int'(dp_round) -: 128];
    dp_result = aes_round(dp_state, round_key, dp_last);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard: transfers are predicted at the negedge before the edge.
  initial begin
    bit ov_prev;
    ov_prev = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (in_valid && in_ready) begin
          if (b2b && last_acc >= 0) check("accept_spacing", 128'(cyc + 1 - last_acc), 128'(NR + 2));
          last_acc = cyc + 1;
          acc_edge = cyc + 1;
          exp_q.push_back(aes_encrypt(in_block, cur_key));
        end
        if (out_valid && !ov_prev) check("latency", 128'(cyc - acc_edge), 128'(NR));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", 128'd1, 128'd0);
          else check("ciphertext", out_block, exp_q.pop_front());
        end
        ov_prev = out_valid;
      end else begin
        ov_prev = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] pt);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_block = pt;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 100) break;
      n++;
      step();
    end
    check("accept_timeout", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd_ready);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
    out_ready = 1'b0;
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dp_round != r && n < 50);
    check("wait_round", 128'(dp_round), 128'(r));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_dp_last"}, 128'(dp_last), 128'd0);
    check({tag, "_dp_round"}, 128'(dp_round), 128'd0);
    check({tag, "_dp_state"}, dp_state, 128'd0);
    check({tag, "_out_block"}, out_block, 128'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // FIPS-197 C.1 with round tracking and a 20-cycle output stall.
    step();
    cur_key = FIPS_KEY;
    in_valid = 1'b1;
    in_block = FIPS_PT;
    @(negedge clk);
    check("idle_dp_round", 128'(dp_round), 128'd0);
    check("idle_in_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      check("dp_round", 128'(dp_round), 128'(k));
      check("dp_last", 128'(dp_last), 128'(k == NR));
      check("round_in_ready", 128'(in_ready), 128'd0);
      check("round_out_valid", 128'(out_valid), 128'd0);
    end
    in_valid = 1'b1;
    in_block = 128'hdeadbeef;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stall_out_valid", 128'(out_valid), 128'd1);
      check("stall_out_block", out_block, FIPS_CT);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      check("stall_dp_last", 128'(dp_last), 128'd0);
    end
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("release_in_ready", 128'(in_ready), 128'd1);
    check("release_out_valid", 128'(out_valid), 128'd0);
    check("fips_drained", 128'(exp_q.size()), 128'd0);

    // Back-to-back: in_valid held high across three blocks.
    b2b = 1;
    last_acc = -1;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    begin
      int accepts, n;
      accepts = 0;
      n = 0;
      while (accepts < 3 && n < 100) begin
        @(negedge clk);
        if (in_valid && in_ready) accepts++;
        step();
        in_block = {$urandom, $urandom, $urandom, $urandom};
        n++;
      end
      check("b2b_accepts", 128'(accepts), 128'd3);
    end
    in_valid = 1'b0;
    drain(0);
    b2b = 0;

    // Asynchronous reset in the middle of round 5.
    step();
    in_valid = 1'b1;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    step();
    in_valid = 1'b0;
    wait_round(4'd5);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("after_reset_no_out", 128'(out_valid), 128'd0);
    end
    step();
    send_block({$urandom, $urandom, $urandom, $urandom});
    drain(0);

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort at round 3, then abort while idle.
    step();
    send_block({$urandom, $urandom, $urandom, $urandom});
    wait_round(4'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_dp_round", 128'(dp_round), 128'd0);
    check("abort_dp_state", dp_state, 128'd0);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("abort_no_out", 128'(out_valid), 128'd0);
    end
    step();
    abort = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("abort_idle_in_ready", 128'(in_ready), 128'd0);
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    send_block({$urandom, $urandom, $urandom, $urandom});
    drain(0);
`endif

    // Randomized blocks, keys, input gaps and output backpressure.
    for (int b = 0; b < 8; b++) begin
      step();
      cur_key = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) step();
      send_block({$urandom, $urandom, $urandom, $urandom});
      drain(1);
    end

    step();
    step();
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    check("final_idle", 128'(in_ready), 128'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
